// File: rtl/bit_serializer_pkg.sv
// -----------------------------------------------------------------------------
// bit_serializer_pkg
//   Shared definitions for the bit serializer: FSM state encoding and the
//   default word width / counter width.
//   Optional feature macro: SER_PARITY_EN adds the PARITY state.
// -----------------------------------------------------------------------------
package bit_serializer_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SHIFT  = 2'b01
`ifdef SER_PARITY_EN
    ,
    ST_PARITY = 2'b10
`endif
  } state_t;

endpackage

// File: rtl/ser_shreg.sv
// -----------------------------------------------------------------------------
// ser_shreg
//   WIDTH-bit loadable left-shift register. Zeros are shifted in at the LSB.
//   Load has priority over shift.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset (clears the register)
//   load   in   capture d this edge
//   shift  in   shift left by one this edge
//   d      in   WIDTH-bit load value
//   msb    out  current MSB of the register
// -----------------------------------------------------------------------------
module ser_shreg
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             msb
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = q[WIDTH-1];

endmodule

// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//   Converts a parallel word into an MSB-first serial stream, one bit per
//   cycle, with a registered valid/last qualifier. Back-to-back words are
//   supported: a new word may be accepted on the last bit of a frame.
//   Optional macro SER_PARITY_EN appends an even-parity bit (XOR of all data
//   bits) as the final bit of each frame.
// Parameters:
//   WIDTH  data bits per word (2..32)
//   CNT_W  bit counter width, ceil(log2(WIDTH))
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   in_data    in   parallel word to serialize
//   in_valid   in   in_data is valid this cycle
//   in_ready   out  a word is accepted this cycle if in_valid=1
//   ser_out    out  serial bit (registered)
//   ser_valid  out  ser_out carries a real bit (registered)
//   ser_last   out  final bit of the frame (registered)
// -----------------------------------------------------------------------------
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last
);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             ser_out_n, ser_valid_n, ser_last_n;
  logic             accept, load, shift, shreg_msb;
`ifdef SER_PARITY_EN
  logic             par, par_n;
`endif

  // The shift register is loaded with the word already shifted by one: the
  // MSB goes straight to the ser_out register, so the register's msb is
  // always the next bit to present.
  ser_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .d     ({in_data[WIDTH-2:0], 1'b0}),
    .msb   (shreg_msb)
  );

  // Ready while idle or on the last bit of a frame; held low during reset.
  assign in_ready = reset & ((state == ST_IDLE) | ser_last);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    ser_out_n   = 1'b0;
    ser_valid_n = 1'b0;
    ser_last_n  = 1'b0;
    load        = 1'b0;
    shift       = 1'b0;
`ifdef SER_PARITY_EN
    par_n       = par;
`endif
    if (accept) begin
      state_n     = ST_SHIFT;
      cnt_n       = CNT_W'(WIDTH - 1);
      ser_out_n   = in_data[WIDTH-1];
      ser_valid_n = 1'b1;
      load        = 1'b1;
`ifdef SER_PARITY_EN
      par_n       = ^in_data;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          state_n = ST_IDLE;
        end
        ST_SHIFT: begin
          // cnt is the index of the bit currently on ser_out.
          if (cnt != '0) begin
            ser_out_n   = shreg_msb;
            ser_valid_n = 1'b1;
            shift       = 1'b1;
            cnt_n       = cnt - CNT_W'(1);
`ifndef SER_PARITY_EN
            ser_last_n  = (cnt == CNT_W'(1));
`endif
          end else begin
`ifdef SER_PARITY_EN
            state_n     = ST_PARITY;
            ser_out_n   = par;
            ser_valid_n = 1'b1;
            ser_last_n  = 1'b1;
`else
            state_n     = ST_IDLE;
`endif
          end
        end
`ifdef SER_PARITY_EN
        ST_PARITY: begin
          state_n = ST_IDLE;
        end
`endif
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
`ifdef SER_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ser_out   <= ser_out_n;
      ser_valid <= ser_valid_n;
      ser_last  <= ser_last_n;
`ifdef SER_PARITY_EN
      par       <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer
//   Self-checking bench for bit_serializer. A reference model holds the
//   expected serial stream as a queue of {valid, bit, last} slots: each
//   accepted word appends its bits MSB first (plus the parity bit when
//   SER_PARITY_EN is defined), and one slot is consumed per clock.
// -----------------------------------------------------------------------------
module tb_bit_serializer;

  localparam int W  = 8;
  localparam int CW = 3;
`ifdef SER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         ser_out;
  logic         ser_valid;
  logic         ser_last;

  always #5 clk = ~clk;

  bit_serializer #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_last  (ser_last)
  );

  typedef struct packed {
    logic v;
    logic b;
    logic l;
  } slot_t;

  slot_t cur;
  slot_t pend[$];
  int    n_checks = 0;
  int    n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] d);
    for (int i = W - 1; i >= 0; i--) begin
      pend.push_back('{1'b1, d[i], logic'((i == 0) && !PAR)});
    end
    if (PAR) pend.push_back('{1'b1, ^d, 1'b1});
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, ser_valid, cur.v);
    chk({tag, ".out"},   ser_out,   cur.b);
    chk({tag, ".last"},  ser_last,  cur.l);
  endtask

  // One clock cycle: drive inputs on the falling edge, check in_ready,
  // advance the model across the rising edge, then check the outputs.
  task automatic step(input string tag, input logic r, input logic v, input logic [W-1:0] d);
    logic exp_ready;
    @(negedge clk);
    reset    = r;
    in_valid = v;
    in_data  = d;
    if (!r) begin
      cur = '0;
      pend.delete();
    end
    #1;
    exp_ready = r && (!cur.v || cur.l);
    chk({tag, ".ready"}, in_ready, exp_ready);
    if (v && exp_ready) push_frame(d);
    @(posedge clk);
    #1;
    if (!r) cur = '0;
    else if (pend.size() > 0) cur = pend.pop_front();
    else cur = '0;
    check_outputs(tag);
  endtask

  // Assert reset between clock edges and check the outputs clear at once.
  task automatic mid_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    cur = '0;
    pend.delete();
    check_outputs(tag);
    chk({tag, ".ready"}, in_ready, 1'b0);
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    cur      = '0;

    // Reset held with a valid word offered: nothing accepted.
    for (int i = 0; i < 3; i++) step("rst_hold", 1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 2; i++) step("rst_rel", 1'b1, 1'b0, 8'h00);

    // Single word 1001_0010.
    step("single", 1'b1, 1'b1, 8'b1001_0010);
    for (int i = 0; i < W + 2; i++) step("single", 1'b1, 1'b0, 8'h00);

    // Back-to-back A5 then 3C with valid held high.
    step("b2b", 1'b1, 1'b1, 8'hA5);
    for (int i = 1; i <= W + int'(PAR); i++) step("b2b", 1'b1, 1'b1, 8'h3C);
    for (int i = 0; i < W + 2; i++) step("b2b", 1'b1, 1'b0, 8'h00);

    // Busy ignore: FF offered during an 00 frame.
    step("busy", 1'b1, 1'b1, 8'h00);
    for (int i = 1; i <= W + int'(PAR); i++) step("busy", 1'b1, (i >= 2), 8'hFF);
    for (int i = 0; i < W + 2; i++) step("busy", 1'b1, 1'b0, 8'h00);

    // Parity-relevant words (plain frames in the default build).
    step("par_b0", 1'b1, 1'b1, 8'b1011_0000);
    for (int i = 0; i < W + 1; i++) step("par_b0", 1'b1, 1'b0, 8'h00);
    step("par_ff", 1'b1, 1'b1, 8'hFF);
    for (int i = 0; i < W + 2; i++) step("par_ff", 1'b1, 1'b0, 8'h00);

    // Reset in the middle of an F0 frame, at bit 4.
    step("midrst", 1'b1, 1'b1, 8'hF0);
    for (int i = 0; i < 3; i++) step("midrst", 1'b1, 1'b0, 8'h00);
    mid_reset("midrst_async");
    for (int i = 0; i < 2; i++) step("midrst_hold", 1'b0, 1'b1, 8'hAA);
    for (int i = 0; i < W + 2; i++) step("midrst_after", 1'b1, 1'b0, 8'h00);

    // Random traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      logic r;
      r = ($urandom_range(0, 79) != 0);
      step("rand", r, logic'($urandom_range(0, 1)), W'($urandom));
    end
    for (int i = 0; i < W + 2; i++) step("drain", 1'b1, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
